if_id_stage: RTL and testbench

- Decode-side receiver for the 64-bit fetch-to-decode bundle {instruction[63:32], pc[31:0]}.
- Buffers up to two fetched packets in a skid FIFO with a valid/ready handshake. Handles pipeline flush on a taken branch.
- Presents the unpacked instruction, PC and pre-extracted register/opcode fields to the decoder.
- Sits between the fetch stage and the decoder/register-file read logic.

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/if_id_fifo.sv | 87 ++++++++
 rtl/if_id_stage.sv | 106 ++++++++++
 tb/tb_if_id_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared RV32 constants, instruction field positions and the
//            fetch-to-decode packet layout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    // Field order matches the 64-bit bundle: instruction in the upper half.
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
    } fetch_pkt_t;

endpackage

`default_nettype wire

// File: rtl/if_id_fifo.sv
// ============================================================================
// Module   : if_id_fifo
// Brief    : DEPTH-entry valid/ready skid FIFO with single-cycle flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_push;
    logic             w_pop;

    // Ready looks only at registered occupancy, never at the consumer.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_id_stage.sv
// ============================================================================
// Module   : if_id_stage
// Brief    : Fetch-to-decode receiver: skid buffering, flush, field extract.
//            Optional counters enabled by defining IF_ID_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_stage
    import riscv_pkg::*;
#(
    parameter int                    REG_WIDTH = 32,
    parameter int                    DEPTH     = 2,
    parameter logic [REG_WIDTH-1:0]  NOP_INST  = riscv_pkg::NOP_INST
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [2*REG_WIDTH-1:0] fetch_dec_reg,
    input  logic                   fetch_valid,
    output logic                   fetch_ready,
    input  logic                   flush,
    input  logic                   dec_ready,
    output logic                   dec_valid,
    output logic [REG_WIDTH-1:0]   dec_instruction,
    output logic [REG_WIDTH-1:0]   dec_pc,
    output logic [6:0]             opcode,
    output logic [4:0]             rd_addr,
    output logic [2:0]             funct3,
    output logic [4:0]             rs1_addr,
    output logic [4:0]             rs2_addr,
    output logic [6:0]             funct7
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            flush_drops
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_pkt_t       head_pkt;
    logic [CNT_W-1:0] fifo_count;

    if_id_fifo #(
        .WIDTH (2 * REG_WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (fetch_valid),
        .in_ready  (fetch_ready),
        .in_data   (fetch_dec_reg),
        .out_valid (dec_valid),
        .out_ready (dec_ready),
        .out_data  (head_pkt),
        .count     (fifo_count)
    );

    assign dec_instruction = dec_valid ? head_pkt.instruction : NOP_INST;
    assign dec_pc          = dec_valid ? head_pkt.pc : '0;

    assign opcode   = dec_instruction[OPCODE_MSB:OPCODE_LSB];
    assign rd_addr  = dec_instruction[RD_MSB:RD_LSB];
    assign funct3   = dec_instruction[FUNCT3_MSB:FUNCT3_LSB];
    assign rs1_addr = dec_instruction[RS1_MSB:RS1_LSB];
    assign rs2_addr = dec_instruction[RS2_MSB:RS2_LSB];
    assign funct7   = dec_instruction[FUNCT7_MSB:FUNCT7_LSB];

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_drops_q, flush_drops_d;
    logic [32:0] drop_sum;

    // Dropped packets = everything buffered plus the one on the bus, if any.
    assign drop_sum = {1'b0, flush_drops_q} + 33'(fifo_count) + 33'(fetch_valid);

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_drops_d  = flush_drops_q;
        if (fetch_valid && !fetch_ready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (flush) begin
            flush_drops_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles_q <= '0;
            flush_drops_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_drops_q  <= flush_drops_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_drops  = flush_drops_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// ============================================================================
// Module   : tb_if_id_stage
// Brief    : Directed self-checking bench for if_id_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_stage;

    logic        clk;
    logic        rstn;
    logic [63:0] fetch_dec_reg;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        flush;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] dec_instruction;
    logic [31:0] dec_pc;
    logic [6:0]  opcode;
    logic [4:0]  rd_addr;
    logic [2:0]  funct3;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [6:0]  funct7;
`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_drops;
`endif

    int total = 0;
    int bad   = 0;

    if_id_stage dut (
        .clk             (clk),
        .rstn            (rstn),
        .fetch_dec_reg   (fetch_dec_reg),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .flush           (flush),
        .dec_ready       (dec_ready),
        .dec_valid       (dec_valid),
        .dec_instruction (dec_instruction),
        .dec_pc          (dec_pc),
        .opcode          (opcode),
        .rd_addr         (rd_addr),
        .funct3          (funct3),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .funct7          (funct7)
`ifdef IF_ID_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_drops     (flush_drops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"}, 64'(dec_valid), 64'd0);
        chk({tag, ".inst"},  64'(dec_instruction), 64'h13);
        chk({tag, ".pc"},    64'(dec_pc), 64'd0);
        chk({tag, ".ready"}, 64'(fetch_ready), 64'd1);
        chk({tag, ".opc"},   64'(opcode), 64'h13);
        chk({tag, ".rd"},    64'(rd_addr), 64'd0);
    endtask

    initial begin
        rstn          = 1'b0;
        flush         = 1'b0;
        dec_ready     = 1'b0;
        fetch_valid   = 1'b1;
        fetch_dec_reg = {32'h00500093, 32'h00000004};

        // Reset held with valid input: nothing may enter
        #1;
        chk_empty("rst0");
        tick();
        chk_empty("rst1");
        tick();
        chk_empty("rst2");
        rstn        = 1'b1;
        fetch_valid = 1'b0;
        tick();
        chk_empty("post_rst");

        // Single packet, held until consumed
        fetch_valid   = 1'b1;
        fetch_dec_reg = {32'h00500093, 32'h00000004};
        tick();
        fetch_valid = 1'b0;
        chk("single.valid", 64'(dec_valid), 64'd1);
        chk("single.pc",    64'(dec_pc), 64'h4);
        chk("single.inst",  64'(dec_instruction), 64'h00500093);
        chk("single.opc",   64'(opcode), 64'h13);
        chk("single.rd",    64'(rd_addr), 64'd1);
        chk("single.rs1",   64'(rs1_addr), 64'd0);
        tick();
        chk("single.hold_pc", 64'(dec_pc), 64'h4);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        chk_empty("single.drained");

        // Back-pressure: third packet refused while full
        fetch_valid   = 1'b1;
        fetch_dec_reg = {32'h40315233, 32'h00000000};
        tick();
        chk("bp.ready1", 64'(fetch_ready), 64'd1);
        fetch_dec_reg = {32'h00100113, 32'h00000004};
        tick();
        chk("bp.ready2", 64'(fetch_ready), 64'd0);
        fetch_dec_reg = {32'h00200193, 32'h00000008};
        tick();
        chk("bp.ready3", 64'(fetch_ready), 64'd0);
        chk("bp.head0",  64'(dec_pc), 64'h0);
        chk("bp.opc",    64'(opcode), 64'h33);
        chk("bp.rd",     64'(rd_addr), 64'd4);
        chk("bp.f3",     64'(funct3), 64'd5);
        chk("bp.rs1",    64'(rs1_addr), 64'd2);
        chk("bp.rs2",    64'(rs2_addr), 64'd3);
        chk("bp.f7",     64'(funct7), 64'h20);
        fetch_valid = 1'b0;
        dec_ready   = 1'b1;
        tick();
        chk("bp.head4",   64'(dec_pc), 64'h4);
        chk("bp.inst4",   64'(dec_instruction), 64'h00100113);
        chk("bp.ready4",  64'(fetch_ready), 64'd1);
        tick();
        chk_empty("bp.drained");

        // Streaming: one packet per cycle, pointers wrap several times
        fetch_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fetch_dec_reg = {32'h00000013 | (32'(i) << 7), 32'h100 + 32'(4 * i)};
            tick();
            chk("stream.valid", 64'(dec_valid), 64'd1);
            chk("stream.pc",    64'(dec_pc), 64'(32'h100 + 32'(4 * i)));
            chk("stream.rd",    64'(rd_addr), 64'(i));
            chk("stream.ready", 64'(fetch_ready), 64'd1);
        end
        fetch_valid = 1'b0;
        tick();
        chk_empty("stream.drained");
        dec_ready = 1'b0;

        // Fresh reset so the optional counters start from zero
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        fetch_valid   = 1'b1;
        fetch_dec_reg = {32'h00000013, 32'h00000010};
        tick();
        fetch_dec_reg = {32'h00000013, 32'h00000014};
        tick();
        fetch_dec_reg = {32'h00000013, 32'h00000018};
        tick();
        tick();
        tick();
        chk("flush.pre_pc",    64'(dec_pc), 64'h10);
        chk("flush.pre_ready", 64'(fetch_ready), 64'd0);
`ifdef IF_ID_PERF_EN
        chk("perf.stall", 64'(stall_cycles), 64'd3);
        chk("perf.drops0", 64'(flush_drops), 64'd0);
`endif
        flush = 1'b1;
        tick();
        chk_empty("flush.1");
`ifdef IF_ID_PERF_EN
        chk("perf.drops", 64'(flush_drops), 64'd3);
`endif
        tick();
        chk_empty("flush.2");
`ifdef IF_ID_PERF_EN
        chk("perf.drops_held", 64'(flush_drops), 64'd4);
`endif
        flush       = 1'b0;
        fetch_valid = 1'b0;
        tick();
        chk_empty("flush.after");

        // Asynchronous reset mid-operation
        fetch_valid   = 1'b1;
        fetch_dec_reg = {32'h00500093, 32'h00000020};
        tick();
        fetch_valid = 1'b0;
        chk("areset.pre", 64'(dec_valid), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk_empty("areset.now");
        tick();
        rstn = 1'b1;
        tick();
        chk_empty("areset.after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
